register_file: RTL and testbench

Operand register bank feeding the ALU's A and B inputs: four general-purpose registers (R1–R4) and four scratch registers (S1–S4), each 16 bits. Every register is updated on the clock edge by a shared per-cycle function code, gated by its own enable. Two independent combinational read ports drive ALU A (OutA) and ALU B (OutB). ALUOut is returned to the bank through input I.

---
 rtl/register_file_pkg.sv | 32 +++
 rtl/register_file_reg16_cell.sv | 44 ++++
 rtl/register_file.sv | 71 +++++++
 tb/tb_register_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the ALU operand register bank: data width,
// register function codes and read-port select encodings.
package register_file_pkg;

  // Register and data width of the ALU datapath.
  localparam int WIDTH = 16;

  // Number of registers in the bank (R1..R4 followed by S1..S4).
  localparam int NUM_REGS = 8;

  // Register function codes, shared by every enabled register in a cycle.
  localparam logic [2:0] RF_DEC        = 3'b000;
  localparam logic [2:0] RF_INC        = 3'b001;
  localparam logic [2:0] RF_LOAD       = 3'b010;
  localparam logic [2:0] RF_CLEAR      = 3'b011;
  localparam logic [2:0] RF_LOADL_CLRH = 3'b100;
  localparam logic [2:0] RF_LOADL      = 3'b101;
  localparam logic [2:0] RF_LOADH      = 3'b110;
  localparam logic [2:0] RF_SEXT       = 3'b111;

  // Read-port source encodings. The value doubles as the index of the
  // register in the bank's internal array.
  localparam logic [2:0] SEL_R1 = 3'd0;
  localparam logic [2:0] SEL_R2 = 3'd1;
  localparam logic [2:0] SEL_R3 = 3'd2;
  localparam logic [2:0] SEL_R4 = 3'd3;
  localparam logic [2:0] SEL_S1 = 3'd4;
  localparam logic [2:0] SEL_S2 = 3'd5;
  localparam logic [2:0] SEL_S3 = 3'd6;
  localparam logic [2:0] SEL_S4 = 3'd7;

endpackage

// File: rtl/register_file_reg16_cell.sv
// One 16-bit bank register. When enabled it applies the shared function
// code on the rising clock; otherwise it holds. Asynchronous active-low clear.
module reg16_cell
  import register_file_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_e,
  input  logic [2:0]       i_fun_sel,
  input  logic [WIDTH-1:0] i_i,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Next value for the selected function; byte ops take the low byte of I.
  always_comb begin
    w_next = r_q;
    case (i_fun_sel)
      RF_DEC:        w_next = r_q - 1'b1;
      RF_INC:        w_next = r_q + 1'b1;
      RF_LOAD:       w_next = i_i;
      RF_CLEAR:      w_next = '0;
      RF_LOADL_CLRH: w_next = {8'h00, i_i[7:0]};
      RF_LOADL:      w_next = {r_q[15:8], i_i[7:0]};
      RF_LOADH:      w_next = {i_i[7:0], r_q[7:0]};
      RF_SEXT:       w_next = {{8{i_i[7]}}, i_i[7:0]};
      default:       w_next = r_q;
    endcase
  end

  // State register: asynchronous clear, update only when enabled.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= '0;
    end else if (i_e) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// ALU operand register bank: four general registers R1..R4 and four
// scratch registers S1..S4, a shared function code with per-register
// enables, and two independent combinational read ports.
module register_file
  import register_file_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_i,
  input  logic [2:0]       i_fun_sel,
  input  logic [3:0]       i_reg_sel,
  input  logic [3:0]       i_scr_sel,
  input  logic [2:0]       i_out_a_sel,
  input  logic [2:0]       i_out_b_sel,
  output logic [WIDTH-1:0] o_out_a,
  output logic [WIDTH-1:0] o_out_b
);

  // Enable fan-out: index 0..3 = R1..R4, 4..7 = S1..S4, matching SEL_*.
  logic [NUM_REGS-1:0] w_en;
  logic [WIDTH-1:0]    w_q [NUM_REGS];

  assign w_en = {i_scr_sel, i_reg_sel};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      reg16_cell u_cell (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_e       (w_en[gi]),
        .i_fun_sel (i_fun_sel),
        .i_i       (i_i),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  // Read port A: 8:1 mux, no bypass of same-cycle writes.
  always_comb begin
    o_out_a = '0;
    case (i_out_a_sel)
      SEL_R1:  o_out_a = w_q[0];
      SEL_R2:  o_out_a = w_q[1];
      SEL_R3:  o_out_a = w_q[2];
      SEL_R4:  o_out_a = w_q[3];
      SEL_S1:  o_out_a = w_q[4];
      SEL_S2:  o_out_a = w_q[5];
      SEL_S3:  o_out_a = w_q[6];
      SEL_S4:  o_out_a = w_q[7];
      default: o_out_a = '0;
    endcase
  end

  // Read port B: independent 8:1 mux with the same encoding as port A.
  always_comb begin
    o_out_b = '0;
    case (i_out_b_sel)
      SEL_R1:  o_out_b = w_q[0];
      SEL_R2:  o_out_b = w_q[1];
      SEL_R3:  o_out_b = w_q[2];
      SEL_R4:  o_out_b = w_q[3];
      SEL_S1:  o_out_b = w_q[4];
      SEL_S2:  o_out_b = w_q[5];
      SEL_S3:  o_out_b = w_q[6];
      SEL_S4:  o_out_b = w_q[7];
      default: o_out_b = '0;
    endcase
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a behavioural array model of the
// eight registers, a per-cycle compare process on both read ports, directed
// literal checks from the test plan and a randomized phase with reset pulses.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [2:0]  fun_sel;
  logic [3:0]  reg_sel;
  logic [3:0]  scr_sel;
  logic [2:0]  a_sel;
  logic [2:0]  b_sel;
  logic [15:0] out_a;
  logic [15:0] out_b;

  register_file dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_i         (din),
    .i_fun_sel   (fun_sel),
    .i_reg_sel   (reg_sel),
    .i_scr_sel   (scr_sel),
    .i_out_a_sel (a_sel),
    .i_out_b_sel (b_sel),
    .o_out_a     (out_a),
    .o_out_b     (out_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  // Model: index 0..3 = R1..R4, 4..7 = S1..S4.
  logic [15:0] model [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register function rules expressed as plain arithmetic.
  function automatic logic [15:0] model_next(input logic [2:0] f, input logic [15:0] q,
                                             input logic [15:0] d);
    logic [15:0] lo;
    lo = d & 16'h00FF;
    case (f)
      3'd0:    return 16'((32'(q) + 32'hFFFF) % 32'h10000);
      3'd1:    return 16'((32'(q) + 1) % 32'h10000);
      3'd2:    return d;
      3'd3:    return 16'h0000;
      3'd4:    return lo;
      3'd5:    return (q & 16'hFF00) | lo;
      3'd6:    return 16'(lo * 256) | (q & 16'h00FF);
      default: return d[7] ? (16'hFF00 | lo) : lo;
    endcase
  endfunction

  // Every cycle, away from the active edge, both ports must match the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk($sformatf("cyc_outA sel=%0d", a_sel), out_a, model[a_sel]);
      chk($sformatf("cyc_outB sel=%0d", b_sel), out_b, model[b_sel]);
    end
  end

  // One clock cycle of register activity; model follows the edge.
  task automatic do_cycle(input logic [2:0] f, input logic [15:0] d,
                          input logic [3:0] rs, input logic [3:0] ss);
    logic       live;
    logic [7:0] en;
    @(negedge clk);
    #1;
    fun_sel = f;
    din     = d;
    reg_sel = rs;
    scr_sel = ss;
    en      = {ss, rs};
    @(posedge clk);
    live = rst_n;
    #1;
    if (live) begin
      for (int k = 0; k < 8; k++) begin
        if (en[k]) model[k] = model_next(f, model[k], d);
      end
    end
    reg_sel = 4'h0;
    scr_sel = 4'h0;
    $display("cycle fun=%0d I=%h R=%b S=%b rst_n=%b", f, d, rs, ss, live);
  endtask

  task automatic peek(input string name, input logic [2:0] s, input logic [15:0] exp);
    a_sel = s;
    #1;
    chk(name, out_a, exp);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
  endtask

  logic [15:0] alu_in;
  logic [15:0] alu_reg;

  initial begin
    rst_n   = 1'b0;
    din     = 16'h0;
    fun_sel = 3'd0;
    reg_sel = 4'h0;
    scr_sel = 4'h0;
    a_sel   = 3'd0;
    b_sel   = 3'd0;
    clear_model();

    // Reset state, with clock edges arriving while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outA", out_a, 16'h0000);
    chk("reset_outB", out_b, 16'h0000);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // Asynchronous reset mid-run after loading R1.
    do_cycle(3'd2, 16'h1234, 4'b0001, 4'b0000);
    peek("r1_loaded", 3'd0, 16'h1234);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_r1", out_a, 16'h0000);
    for (int k = 0; k < 8; k++) peek($sformatf("async_rst_sel%0d", k), 3'(k), 16'h0000);
    do_cycle(3'd2, 16'hFFFF, 4'hF, 4'hF);
    rst_n = 1'b1;
    peek("edge_in_reset", 3'd7, 16'h0000);

    // Load fan-out to R1, R3 and S4.
    do_cycle(3'd2, 16'hA5C3, 4'b0101, 4'b1000);
    for (int k = 0; k < 8; k++)
      peek($sformatf("fanout_sel%0d", k), 3'(k),
           (k == 0 || k == 2 || k == 7) ? 16'hA5C3 : 16'h0000);
    a_sel = 3'd0;
    b_sel = 3'd7;
    #1;
    chk("fanout_outA_r1", out_a, 16'hA5C3);
    chk("fanout_outB_s4", out_b, 16'hA5C3);

    // Wrap-around on R2.
    do_cycle(3'd0, 16'h0000, 4'b0010, 4'b0000);
    peek("dec_wrap", 3'd1, 16'hFFFF);
    do_cycle(3'd1, 16'h0000, 4'b0010, 4'b0000);
    peek("inc_wrap", 3'd1, 16'h0000);
    do_cycle(3'd1, 16'h0000, 4'b0010, 4'b0000);
    peek("inc_one", 3'd1, 16'h0001);

    // Byte operations on S1.
    do_cycle(3'd2, 16'h1234, 4'b0000, 4'b0001);
    do_cycle(3'd5, 16'h00F0, 4'b0000, 4'b0001);
    peek("loadl", 3'd4, 16'h12F0);
    do_cycle(3'd6, 16'h00F0, 4'b0000, 4'b0001);
    peek("loadh", 3'd4, 16'hF0F0);
    do_cycle(3'd4, 16'h00F0, 4'b0000, 4'b0001);
    peek("loadl_clrh", 3'd4, 16'h00F0);
    do_cycle(3'd7, 16'h00F0, 4'b0000, 4'b0001);
    peek("sext_neg", 3'd4, 16'hFFF0);
    do_cycle(3'd7, 16'h0070, 4'b0000, 4'b0001);
    peek("sext_pos", 3'd4, 16'h0070);

    // Read during write on R4: old value before the edge, new after.
    do_cycle(3'd2, 16'h0010, 4'b1000, 4'b0000);
    a_sel   = 3'd3;
    fun_sel = 3'd1;
    reg_sel = 4'b1000;
    #1;
    chk("rdw_pre_edge", out_a, 16'h0010);
    do_cycle(3'd1, 16'h0000, 4'b1000, 4'b0000);
    peek("rdw_post_edge", 3'd3, 16'h0011);
    do_cycle(3'd3, 16'h0000, 4'b0000, 4'b0000);
    peek("hold_disabled", 3'd3, 16'h0011);

    // ALU loop: R1 + R2 registered by the ALU, then loaded into S2.
    do_cycle(3'd2, 16'h0003, 4'b0001, 4'b0000);
    do_cycle(3'd2, 16'h0004, 4'b0010, 4'b0000);
    a_sel = 3'd0;
    b_sel = 3'd1;
    @(negedge clk);
    alu_in = out_a + out_b;
    @(posedge clk);
    alu_reg = alu_in;
    #1;
    chk("alu_sum", alu_reg, 16'h0007);
    do_cycle(3'd2, alu_reg, 4'b0000, 4'b0010);
    peek("alu_loop_s2", 3'd5, 16'h0007);

    // Randomized phase with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        clear_model();
        do_cycle(3'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
        rst_n = 1'b1;
      end else begin
        do_cycle(3'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      end
      a_sel = 3'($urandom);
      b_sel = ($urandom_range(0, 3) == 0) ? a_sel : 3'($urandom);
    end

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
